// File: rtl/msx_cart_sequencer_if.sv
// Save and zero-fill handshake bundle between the cartridge sequencer
// (master) and the HPS save logic / SRAM write mux (slave).
interface msx_cart_sequencer_if;
    logic        save_req;
    logic        save_slot;
    logic        save_ack;
    logic        clr_req;
    logic        clr_slot;
    logic [14:0] clr_addr;
    logic        clr_ack;

    modport master (
        output save_req, save_slot, clr_req, clr_slot, clr_addr,
        input  save_ack, clr_ack
    );

    modport slave (
        input  save_req, save_slot, clr_req, clr_slot, clr_addr,
        output save_ack, clr_ack
    );
endinterface

// File: rtl/msx_cart_sequencer.sv
// Cartridge/config change sequencer: holds the MSX in reset, waits for the
// configuration to settle, saves dirty cartridge SRAM, zero-fills the new
// SRAM regions and releases reset after a minimum hold.
//
// state  | meaning
// IDLE   | MSX running, watching for config/cart events
// SETTLE | MSX in reset, waiting for SETTLE_CYCLES quiet cycles
// SAVE   | asking the HPS to save dirty SRAM, slot 0 then slot 1
// CLEAR  | zero-filling SRAM of changed slots, slot 0 then slot 1
// HOLD   | minimum reset hold before releasing the MSX
module msx_cart_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SAVE_TIMEOUT  = 1048576
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        reset_request,
    input  logic [1:0]                  cart_changed,
    input  logic [2:0]                  sram_size_a,
    input  logic [2:0]                  sram_size_b,
    input  logic [1:0]                  sram_dirty,
    msx_cart_sequencer_if.master        bus,
    output logic                        msx_reset,
    output logic                        busy
);

    localparam int unsigned MAX_A   = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > SAVE_TIMEOUT) ? MAX_A : SAVE_TIMEOUT;
    localparam int          CW      = $clog2(MAX_CNT) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAVE, S_CLEAR, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pending_q, pending_d;
    logic [1:0]    dirty_l_q, dirty_l_d;
    logic          restart_q, restart_d;
    logic          slot_q, slot_d;
    logic          save_req_q, save_req_d;
    logic          save_slot_q, save_slot_d;
    logic          clr_req_q, clr_req_d;
    logic          clr_slot_q, clr_slot_d;
    logic [14:0]   clr_addr_q, clr_addr_d;
    logic          msx_reset_q, msx_reset_d;

    logic          event_w;
    logic          restart_w;
    logic [2:0]    size_w;
    logic          size_ok_w;
    logic [14:0]   last_addr_w;

    assign event_w     = reset_request | cart_changed[0] | cart_changed[1];
    assign restart_w   = restart_q | event_w;
    assign size_w      = slot_q ? sram_size_b : sram_size_a;
    assign size_ok_w   = (size_w != 3'd0) && (size_w != 3'd7);
    // Region is 512 << size bytes; the largest (size 6) ends at 32767.
    assign last_addr_w = 15'((16'd512 << size_w) - 16'd1);

    // State and handshake registers; reset lands in HOLD for a power-up pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            pending_q   <= 2'b00;
            dirty_l_q   <= 2'b00;
            restart_q   <= 1'b0;
            slot_q      <= 1'b0;
            save_req_q  <= 1'b0;
            save_slot_q <= 1'b0;
            clr_req_q   <= 1'b0;
            clr_slot_q  <= 1'b0;
            clr_addr_q  <= 15'd0;
            msx_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            dirty_l_q   <= dirty_l_d;
            restart_q   <= restart_d;
            slot_q      <= slot_d;
            save_req_q  <= save_req_d;
            save_slot_q <= save_slot_d;
            clr_req_q   <= clr_req_d;
            clr_slot_q  <= clr_slot_d;
            clr_addr_q  <= clr_addr_d;
            msx_reset_q <= msx_reset_d;
        end
    end

    // Next-state logic: event tracking, settle/hold timers, save and clear handshakes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q | cart_changed;
        dirty_l_d   = dirty_l_q | (sram_dirty & cart_changed);
        restart_d   = restart_q;
        slot_d      = slot_q;
        save_req_d  = save_req_q;
        save_slot_d = save_slot_q;
        clr_req_d   = clr_req_q;
        clr_slot_d  = clr_slot_q;
        clr_addr_d  = clr_addr_q;

        case (state_q)
            S_IDLE: begin
                if (event_w) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                restart_d = 1'b0;
                if (event_w) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAVE;
                    slot_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAVE: begin
                if (event_w) restart_d = 1'b1;
                if (save_req_q) begin
                    if (bus.save_ack || (cnt_q == CW'(SAVE_TIMEOUT - 1))) begin
                        save_req_d        = 1'b0;
                        // Only a change arriving this very cycle may re-mark the slot dirty.
                        dirty_l_d[slot_q] = sram_dirty[slot_q] & cart_changed[slot_q];
                        cnt_d             = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (restart_w) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (pending_q[slot_q] && dirty_l_q[slot_q]) begin
                    save_req_d  = 1'b1;
                    save_slot_d = slot_q;
                    cnt_d       = '0;
                end else if (!slot_q) begin
                    slot_d = 1'b1;
                end else begin
                    state_d = S_CLEAR;
                    slot_d  = 1'b0;
                end
            end
            S_CLEAR: begin
                if (event_w) restart_d = 1'b1;
                if (clr_req_q) begin
                    if (bus.clr_ack) begin
                        if (clr_addr_q == last_addr_w) begin
                            clr_req_d  = 1'b0;
                            clr_addr_d = 15'd0;
                            if (!slot_q) begin
                                slot_d = 1'b1;
                            end else begin
                                state_d = restart_w ? S_SETTLE : S_HOLD;
                                cnt_d   = '0;
                            end
                        end else if (restart_w) begin
                            clr_req_d  = 1'b0;
                            clr_addr_d = 15'd0;
                        end else begin
                            clr_addr_d = clr_addr_q + 15'd1;
                        end
                    end
                end else if (restart_w) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (pending_q[slot_q] && size_ok_w) begin
                    clr_req_d  = 1'b1;
                    clr_slot_d = slot_q;
                    clr_addr_d = 15'd0;
                end else if (!slot_q) begin
                    slot_d = 1'b1;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (event_w) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    pending_d = 2'b00;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // msx_reset is registered from the next state so it tracks busy exactly.
    assign msx_reset_d   = (state_d != S_IDLE);
    assign msx_reset     = msx_reset_q;
    assign busy          = (state_q != S_IDLE);
    assign bus.save_req  = save_req_q;
    assign bus.save_slot = save_slot_q;
    assign bus.clr_req   = clr_req_q;
    assign bus.clr_slot  = clr_slot_q;
    assign bus.clr_addr  = clr_addr_q;

endmodule

// File: tb/tb_msx_cart_sequencer.sv
// Bench for msx_cart_sequencer: randomized handshake responders, a monitor
// that logs save/clear transactions, and a transaction-level expectation
// model built from the change/dirty/size inputs of each scenario.
module tb_msx_cart_sequencer;
    localparam int SETTLE = 64;
    localparam int HOLD   = 16;
    localparam int TMO    = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       reset_request = 1'b0;
    logic [1:0] cart_changed = 2'b00;
    logic [2:0] sram_size_a = 3'd0;
    logic [2:0] sram_size_b = 3'd0;
    logic [1:0] sram_dirty = 2'b00;
    logic       msx_reset;
    logic       busy;

    msx_cart_sequencer_if bus();

    msx_cart_sequencer #(
        .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD), .SAVE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .reset_request(reset_request),
        .cart_changed(cart_changed), .sram_size_a(sram_size_a), .sram_size_b(sram_size_b),
        .sram_dirty(sram_dirty), .bus(bus), .msx_reset(msx_reset), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  clr_pct   = 100;
    int  save_mode = 0;
    bit  stray_en  = 1'b0;

    logic [15:0] clr_log[$];
    logic [15:0] exp_clr[$];
    int          clr_cyc[$];
    int          save_log[$];
    int          exp_save[$];
    int          len_log[$];
    int          viol = 0;

    // Handshake responders for the HPS save port and the SRAM write port.
    initial begin
        int save_wait;
        int save_delay;
        save_wait  = 0;
        save_delay = 1;
        bus.save_ack = 1'b0;
        bus.clr_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.clr_ack  = 1'b0;
            bus.save_ack = 1'b0;
            if (bus.clr_req === 1'b1 && $urandom_range(0, 99) < clr_pct) bus.clr_ack = 1'b1;
            if (bus.save_req === 1'b1) begin
                save_wait++;
                if (save_mode == 0 && save_wait >= save_delay) bus.save_ack = 1'b1;
            end else begin
                save_wait  = 0;
                save_delay = $urandom_range(1, 20);
                if (stray_en && $urandom_range(0, 99) < 5) bus.save_ack = 1'b1;
            end
        end
    end

    // Transaction monitor and protocol invariants.
    initial begin
        logic        p_save_req, p_save_slot, p_clr_req, p_clr_ack, p_clr_slot;
        logic [14:0] p_addr;
        int          save_len;
        p_save_req = 0; p_save_slot = 0; p_clr_req = 0; p_clr_ack = 0; p_clr_slot = 0;
        p_addr = 0; save_len = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.save_req && bus.clr_req) viol++;
                if (msx_reset !== busy) viol++;
                if (bus.clr_req && p_clr_req &&
                    (bus.clr_addr !== (p_clr_ack ? p_addr + 15'd1 : p_addr) || bus.clr_slot !== p_clr_slot))
                    viol++;
                if (bus.save_req && p_save_req && bus.save_slot !== p_save_slot) viol++;
                if (bus.save_req && !p_save_req) save_log.push_back(int'(bus.save_slot));
                if (bus.save_req) save_len++;
                else if (p_save_req) begin
                    len_log.push_back(save_len);
                    save_len = 0;
                end
                if (bus.clr_req && bus.clr_ack) begin
                    clr_log.push_back({bus.clr_slot, bus.clr_addr});
                    clr_cyc.push_back(cyc);
                end
            end
            p_save_req = bus.save_req; p_save_slot = bus.save_slot;
            p_clr_req = bus.clr_req; p_clr_ack = bus.clr_ack;
            p_clr_slot = bus.clr_slot; p_addr = bus.clr_addr;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        clr_log.delete(); exp_clr.delete(); clr_cyc.delete();
        save_log.delete(); exp_save.delete(); len_log.delete();
        viol = 0;
    endtask

    // Reference: which slots get saved and which byte addresses get zeroed.
    task automatic expect_run(input logic [1:0] cc, input logic [1:0] dirty,
                              input logic [2:0] sa, input logic [2:0] sb);
        for (int i = 0; i < 2; i++)
            if (cc[i] && dirty[i]) exp_save.push_back(i);
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = (i == 0) ? int'(sa) : int'(sb);
            if (cc[i] && sz >= 1 && sz <= 6)
                for (int a = 0; a < (512 << sz); a++) exp_clr.push_back(16'((i << 15) | a));
        end
    endtask

    function automatic int clr_diff();
        int n;
        n = (clr_log.size() > exp_clr.size()) ? clr_log.size() - exp_clr.size()
                                              : exp_clr.size() - clr_log.size();
        for (int i = 0; i < clr_log.size() && i < exp_clr.size(); i++)
            if (clr_log[i] !== exp_clr[i]) n++;
        return n;
    endfunction

    function automatic int save_diff();
        int n;
        n = (save_log.size() > exp_save.size()) ? save_log.size() - exp_save.size()
                                                : exp_save.size() - save_log.size();
        for (int i = 0; i < save_log.size() && i < exp_save.size(); i++)
            if (save_log[i] != exp_save[i]) n++;
        return n;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic kick(input logic [1:0] cc, input logic rr);
        @(negedge clk);
        cart_changed  = cc;
        reset_request = rr;
        @(negedge clk);
        cart_changed  = 2'b00;
        reset_request = 1'b0;
    endtask

    task automatic count_pulse(output int n);
        n = 0;
        while (msx_reset === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk);
        checks++;
        if (msx_reset !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: msx_reset=%b busy=%b, required 1 1", msx_reset, busy);
        end
        checks++;
        if (bus.save_req !== 1'b0 || bus.clr_req !== 1'b0 || bus.clr_addr !== 15'd0) begin
            errors++;
            $display("FAIL reset_bus: save_req=%b clr_req=%b clr_addr=%0d, required 0 0 0",
                     bus.save_req, bus.clr_req, bus.clr_addr);
        end
        reset_n = 1'b1;
        count_pulse(n);
        checks++;
        if (n != HOLD) begin
            errors++;
            $display("FAIL powerup_pulse: msx_reset high %0d cycles, required %0d", n, HOLD);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL powerup_busy: busy=%b when msx_reset fell, required 0", busy);
        end
    endtask

    task automatic test_settle_glitch();
        int  d, t1, r;
        bit  ok;
        clear_logs();
        sram_dirty = 2'b01; sram_size_a = 3'd0; sram_size_b = 3'd0;
        expect_run(2'b01, 2'b01, 3'd0, 3'd0);
        checks++;
        if (msx_reset !== 1'b0) begin
            errors++;
            $display("FAIL idle_reset: msx_reset=%b before event, required 0", msx_reset);
        end
        kick(2'b01, 1'b0);
        checks++;
        if (msx_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_rise: msx_reset=%b one cycle after event, required 1", msx_reset);
        end
        d = $urandom_range(SETTLE / 2, SETTLE - 8);
        repeat (d) @(negedge clk);
        @(negedge clk);
        cart_changed = 2'b01;
        t1 = cyc + 1;
        @(negedge clk);
        cart_changed = 2'b00;
        r = -1;
        for (int i = 0; i < 3 * SETTLE; i++) begin
            if (bus.save_req === 1'b1) begin
                r = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (r < t1 + SETTLE + 1 || r > t1 + SETTLE + 4) begin
            errors++;
            $display("FAIL settle_restart: save_req rose at cycle %0d, required within %0d..%0d",
                     r, t1 + SETTLE + 1, t1 + SETTLE + 4);
        end
        wait_idle(2000, ok);
        checks++;
        if (!ok || save_diff() != 0 || clr_diff() != 0 || viol != 0) begin
            errors++;
            $display("FAIL glitch_seq: idle=%0b saves=%0d clears=%0d viol=%0d, required 1 1 0 0",
                     ok, save_log.size(), clr_log.size(), viol);
        end
    endtask

    task automatic test_save_clear();
        bit ok;
        int last, f;
        clear_logs();
        save_mode = 0; clr_pct = 70;
        sram_dirty = 2'b01; sram_size_a = 3'd1; sram_size_b = 3'd5;
        expect_run(2'b01, 2'b01, 3'd1, 3'd5);
        kick(2'b01, 1'b0);
        wait_idle(6000, ok);
        f = cyc;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL save_clear_idle: busy still high after budget, required idle");
        end
        checks++;
        if (save_diff() != 0) begin
            errors++;
            $display("FAIL save_clear_saves: %0d saves (first slot %0d), required 1 of slot 0",
                     save_log.size(), (save_log.size() > 0) ? save_log[0] : -1);
        end
        checks++;
        if (clr_diff() != 0) begin
            errors++;
            $display("FAIL save_clear_writes: %0d writes with %0d differences, required %0d",
                     clr_log.size(), clr_diff(), exp_clr.size());
        end
        last = (clr_cyc.size() > 0) ? clr_cyc[clr_cyc.size() - 1] + 1 : 0;
        checks++;
        if (f - last < HOLD || f - last > HOLD + 3) begin
            errors++;
            $display("FAIL save_clear_hold: release %0d cycles after last write, required %0d..%0d",
                     f - last, HOLD, HOLD + 3);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL save_clear_protocol: %0d violations, required 0", viol);
        end
    endtask

    task automatic test_both_slots();
        bit ok;
        clear_logs();
        save_mode = 0; clr_pct = 100;
        sram_dirty = 2'b00; sram_size_a = 3'd7; sram_size_b = 3'd4;
        expect_run(2'b11, 2'b00, 3'd7, 3'd4);
        kick(2'b11, 1'b0);
        wait_idle(20000, ok);
        checks++;
        if (!ok || save_log.size() != 0) begin
            errors++;
            $display("FAIL both_saves: idle=%0b saves=%0d, required 1 0", ok, save_log.size());
        end
        checks++;
        if (clr_diff() != 0 || viol != 0) begin
            errors++;
            $display("FAIL both_writes: %0d writes, %0d differences, viol=%0d, required %0d 0 0",
                     clr_log.size(), clr_diff(), viol, exp_clr.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        save_mode = 1; clr_pct = 80;
        sram_dirty = 2'b10; sram_size_a = 3'd3; sram_size_b = 3'd1;
        expect_run(2'b10, 2'b10, 3'd3, 3'd1);
        kick(2'b10, 1'b0);
        wait_idle(6000, ok);
        save_mode = 0;
        checks++;
        if (len_log.size() != 1 || len_log[0] != TMO) begin
            errors++;
            $display("FAIL timeout_len: %0d save pulses, first %0d cycles, required 1 of %0d",
                     len_log.size(), (len_log.size() > 0) ? len_log[0] : 0, TMO);
        end
        checks++;
        if (!ok || save_diff() != 0 || clr_diff() != 0 || viol != 0) begin
            errors++;
            $display("FAIL timeout_seq: idle=%0b saves=%0d writes=%0d viol=%0d, required 1 1 %0d 0",
                     ok, save_log.size(), clr_log.size(), viol, exp_clr.size());
        end
    endtask

    task automatic test_mid_clear();
        bit ok;
        int te;
        clear_logs();
        save_mode = 0; clr_pct = 60;
        sram_dirty = 2'b00; sram_size_a = 3'd1; sram_size_b = 3'd0;
        for (int a = 0; a <= 100; a++) exp_clr.push_back(16'(a));
        expect_run(2'b01, 2'b00, 3'd1, 3'd0);
        kick(2'b01, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.clr_req === 1'b1 && bus.clr_slot === 1'b0 && bus.clr_addr === 15'd100) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_clear_reach: clear never reached addr 100, required to");
        end
        reset_request = 1'b1;
        te = cyc + 1;
        @(negedge clk);
        reset_request = 1'b0;
        wait_idle(8000, ok);
        checks++;
        if (!ok || clr_diff() != 0 || viol != 0) begin
            errors++;
            $display("FAIL mid_clear_writes: idle=%0b %0d writes, %0d differences, viol=%0d, required 1 %0d 0 0",
                     ok, clr_log.size(), clr_diff(), viol, exp_clr.size());
        end
        checks++;
        if (clr_cyc.size() <= 101 || clr_cyc[101] < te + SETTLE) begin
            errors++;
            $display("FAIL mid_clear_settle: restart write at cycle %0d, required at or after %0d",
                     (clr_cyc.size() > 101) ? clr_cyc[101] : -1, te + SETTLE);
        end
    endtask

    task automatic test_reset_midseq();
        bit ok;
        int n;
        clear_logs();
        sram_dirty = 2'b01; sram_size_a = 3'd1; sram_size_b = 3'd0;
        kick(2'b01, 1'b0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (msx_reset !== 1'b1 || bus.save_req !== 1'b0 || bus.clr_req !== 1'b0) begin
            errors++;
            $display("FAIL midseq_reset: msx_reset=%b save_req=%b clr_req=%b, required 1 0 0",
                     msx_reset, bus.save_req, bus.clr_req);
        end
        reset_n = 1'b1;
        count_pulse(n);
        checks++;
        if (n != HOLD) begin
            errors++;
            $display("FAIL midseq_pulse: msx_reset high %0d cycles, required %0d", n, HOLD);
        end
        repeat (2 * SETTLE) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || save_log.size() != 0 || clr_log.size() != 0) begin
            errors++;
            $display("FAIL midseq_forget: busy=%b saves=%0d writes=%0d, required 0 0 0",
                     busy, save_log.size(), clr_log.size());
        end
    endtask

    task automatic test_random();
        logic [2:0] sizes[4] = '{3'd0, 3'd1, 3'd2, 3'd7};
        stray_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            bit         ok;
            int         kind;
            logic [1:0] cc, dirty;
            logic       rr;
            clear_logs();
            kind = $urandom_range(0, 3);
            cc = 2'(kind);
            rr = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dirty = 2'($urandom_range(0, 3));
            sram_dirty  = dirty;
            sram_size_a = sizes[$urandom_range(0, 3)];
            sram_size_b = sizes[$urandom_range(0, 3)];
            clr_pct = $urandom_range(60, 100);
            expect_run(cc, dirty, sram_size_a, sram_size_b);
            kick(cc, rr);
            wait_idle(12000, ok);
            checks++;
            if (!ok || save_diff() != 0 || clr_diff() != 0 || viol != 0) begin
                errors++;
                $display("FAIL random_%0d: cc=%b dirty=%b sizes=%0d/%0d idle=%0b saves=%0d/%0d writes=%0d/%0d viol=%0d",
                         it, cc, dirty, sram_size_a, sram_size_b, ok, save_log.size(), exp_save.size(),
                         clr_log.size(), exp_clr.size(), viol);
            end
        end
        stray_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_settle_glitch();
        test_save_clear();
        test_both_slots();
        test_timeout();
        test_mid_clear();
        test_reset_midseq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
